// File: rtl/alu_issue_arbiter_if.sv
// Request, ALU-drive and response signals of the shared-ALU issue arbiter.
// slave is the arbiter's view; master is the requesters/ALU/consumer view.
interface alu_issue_arbiter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned INS_W = 7
);
  logic             req0_valid;
  logic             req0_ready;
  logic [INS_W-1:0] req0_ins;
  logic [XLEN-1:0]  req0_srca;
  logic [XLEN-1:0]  req0_srcb;

  logic             req1_valid;
  logic             req1_ready;
  logic [INS_W-1:0] req1_ins;
  logic [XLEN-1:0]  req1_srca;
  logic [XLEN-1:0]  req1_srcb;

  logic [INS_W-1:0] alu_ins;
  logic [XLEN-1:0]  alu_srca;
  logic [XLEN-1:0]  alu_srcb;
  logic [XLEN-1:0]  alu_result;
  logic             alu_zero;
  logic             alu_sign;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [XLEN-1:0]  rsp_result;
  logic             rsp_zero;
  logic             rsp_sign;

  modport slave (
    input  req0_valid, req0_ins, req0_srca, req0_srcb,
    output req0_ready,
    input  req1_valid, req1_ins, req1_srca, req1_srcb,
    output req1_ready,
    output alu_ins, alu_srca, alu_srcb,
    input  alu_result, alu_zero, alu_sign,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_ins, req0_srca, req0_srcb,
    input  req0_ready,
    output req1_valid, req1_ins, req1_srca, req1_srcb,
    input  req1_ready,
    input  alu_ins, alu_srca, alu_srcb,
    output alu_result, alu_zero, alu_sign,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter sharing one ALU_unit between two requesters:
// issue register (s1) drives the ALU, response register (s2) holds the result.
module alu_issue_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned INS_W = 7
) (
  input  logic                clk,
  input  logic                reset,
  alu_issue_arbiter_if.slave  bus
);

  logic             s1_valid;
  logic             s1_id;
  logic [INS_W-1:0] s1_ins;
  logic [XLEN-1:0]  s1_srca;
  logic [XLEN-1:0]  s1_srcb;

  logic             s2_valid;
  logic             s2_id;
  logic [XLEN-1:0]  s2_result;
  logic             s2_zero;
  logic             s2_sign;

  logic             last_grant;

  logic             s2_adv;
  logic             s1_adv;
  logic             can_accept;
  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic [INS_W-1:0] sel_ins;
  logic [XLEN-1:0]  sel_srca;
  logic [XLEN-1:0]  sel_srcb;

  always_comb begin
    s2_adv     = ~s2_valid | bus.rsp_ready;
    s1_adv     = s1_valid & s2_adv;
    can_accept = ~s1_valid | s2_adv;
  end

  // On contention the requester that did not win the last accept goes next.
  always_comb begin
    grant_any = bus.req0_valid | bus.req1_valid;
    grant_id  = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    accept         = can_accept & grant_any & ~reset;
    bus.req0_ready = accept & ~grant_id;
    bus.req1_ready = accept & grant_id;
  end

  always_comb begin
    sel_ins  = bus.req0_ins;
    sel_srca = bus.req0_srca;
    sel_srcb = bus.req0_srcb;
    if (grant_id) begin
      sel_ins  = bus.req1_ins;
      sel_srca = bus.req1_srca;
      sel_srcb = bus.req1_srcb;
    end
  end

  // Issue stage: operands stay put when it drains because the ALU has no valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_ins     <= '0;
      s1_srca    <= '0;
      s1_srcb    <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_id      <= grant_id;
      s1_ins     <= sel_ins;
      s1_srca    <= sel_srca;
      s1_srcb    <= sel_srcb;
      last_grant <= grant_id;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  // Response stage: a new capture may coincide with the consumer taking the old one.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_id     <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_sign   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid  <= 1'b1;
      s2_id     <= s1_id;
      s2_result <= bus.alu_result;
      s2_zero   <= bus.alu_zero;
      s2_sign   <= bus.alu_sign;
    end else if (s2_valid && bus.rsp_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  always_comb begin
    bus.alu_ins    = s1_ins;
    bus.alu_srca   = s1_srca;
    bus.alu_srcb   = s1_srcb;
    bus.rsp_valid  = s2_valid;
    bus.rsp_id     = s2_id;
    bus.rsp_result = s2_result;
    bus.rsp_zero   = s2_zero;
    bus.rsp_sign   = s2_sign;
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: a behavioural ALU_unit stub, a response
// scoreboard fed on accept, table-driven vectors and multi-cycle sequences.
module tb_alu_issue_arbiter;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned INS_W = 7;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        z;
    logic        s;
  } exp_t;

  typedef struct {
    logic        id;
    logic [6:0]  ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        s;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  exp_t q[$];
  exp_t exp0;
  exp_t exp1;
  vec_t vecs[8];

  always #5 clk = ~clk;

  alu_issue_arbiter_if #(.XLEN(XLEN), .INS_W(INS_W)) bif ();

  alu_issue_arbiter #(.XLEN(XLEN), .INS_W(INS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  // ins = {opb5, funct7b5, funct3, ALUOp}; returns {zero, sign, result}
  function automatic logic [33:0] alu_model(input logic [6:0] ins, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    case (ins[1:0])
      2'b00: r = a + b;
      2'b01: r = a - b;
      default: begin
        case (ins[4:2])
          3'b000: r = (ins[6] & ins[5]) ? a - b : a + b;
          3'b001: r = a << b[4:0];
          3'b010: r = {31'b0, $signed(a) < $signed(b)};
          3'b011: r = {31'b0, a < b};
          3'b100: r = a ^ b;
          3'b101: r = ins[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'b110: r = a | b;
          default: r = a & b;
        endcase
      end
    endcase
    return {r == 32'd0, r[31], r};
  endfunction

  assign {bif.alu_zero, bif.alu_sign, bif.alu_result} =
    alu_model(bif.alu_ins, bif.alu_srca, bif.alu_srcb);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [6:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input exp_t e);
    if (!id) begin
      bif.req0_ins = ins; bif.req0_srca = a; bif.req0_srcb = b;
      exp0 = e; bif.req0_valid = 1'b1;
    end else begin
      bif.req1_ins = ins; bif.req1_srca = a; bif.req1_srcb = b;
      exp1 = e; bif.req1_valid = 1'b1;
    end
  endtask

  task automatic clear(input logic id);
    if (!id) bif.req0_valid = 1'b0;
    else     bif.req1_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !bif.rsp_valid) break;
      tick();
    end
    chk("drain_queue", 64'(q.size()), 64'd0);
    chk("drain_rsp_valid", bif.rsp_valid, 1'b0);
  endtask

  // Scoreboard: push on accept, pop on response handshake, and require a
  // stalled response to stay unchanged until it is taken.
  logic        held_v = 1'b0;
  logic [35:0] held;
  exp_t        got_e;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("rsp_hold", {bif.rsp_valid, bif.rsp_id, bif.rsp_zero, bif.rsp_sign, bif.rsp_result}, held);
      held_v = bif.rsp_valid & ~bif.rsp_ready;
      held   = {bif.rsp_valid, bif.rsp_id, bif.rsp_zero, bif.rsp_sign, bif.rsp_result};
      if (bif.rsp_valid && bif.rsp_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_spurious: got id=%0d result=%0h want no response at %0t",
                   bif.rsp_id, bif.rsp_result, $time);
        end else begin
          got_e = q.pop_front();
          chk("rsp_id", bif.rsp_id, got_e.id);
          chk("rsp_result", bif.rsp_result, got_e.res);
          chk("rsp_zero", bif.rsp_zero, got_e.z);
          chk("rsp_sign", bif.rsp_sign, got_e.s);
        end
      end
      if (bif.req0_valid && bif.req0_ready) q.push_back(exp0);
      if (bif.req1_valid && bif.req1_ready) q.push_back(exp1);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  logic [6:0] rops[8];
  initial begin
    logic [33:0] m;
    logic [6:0]  ins;
    logic [31:0] a;
    logic [31:0] b;
    logic        acc0;
    logic        acc1;

    vecs[0] = '{1'b0, 7'b0000000, 32'd5,          32'd3,      32'd8,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 7'b0000001, 32'd3,          32'd5,      32'hFFFFFFFE,   1'b0, 1'b1};
    vecs[2] = '{1'b0, 7'b0000001, 32'd7,          32'd7,      32'd0,          1'b1, 1'b0};
    vecs[3] = '{1'b1, 7'b0000000, 32'h7FFFFFFF,   32'd1,      32'h80000000,   1'b0, 1'b1};
    vecs[4] = '{1'b0, 7'b0011010, 32'd12,         32'd3,      32'd15,         1'b0, 1'b0};
    vecs[5] = '{1'b1, 7'b0011110, 32'h0000F0F0,   32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 7'b0010010, 32'd5,          32'd5,      32'd0,          1'b1, 1'b0};
    vecs[7] = '{1'b1, 7'b1100010, 32'd10,         32'd4,      32'd6,          1'b0, 1'b0};
    rops = '{7'b0000000, 7'b0000001, 7'b0011010, 7'b0011110,
             7'b0010010, 7'b1100010, 7'b0000110, 7'b0001110};

    bif.req0_valid = 1'b0; bif.req0_ins = '0; bif.req0_srca = '0; bif.req0_srcb = '0;
    bif.req1_valid = 1'b0; bif.req1_ins = '0; bif.req1_srca = '0; bif.req1_srcb = '0;
    bif.rsp_ready  = 1'b1;
    reset = 1'b1;
    repeat (3) tick();

    // Reset state; readies forced low even with both requesters valid.
    bif.req0_valid = 1'b1;
    bif.req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bif.req0_ready, 1'b0);
    chk("rst_req1_ready", bif.req1_ready, 1'b0);
    chk("rst_rsp_valid", bif.rsp_valid, 1'b0);
    chk("rst_rsp_id", bif.rsp_id, 1'b0);
    chk("rst_rsp_result", bif.rsp_result, 32'd0);
    chk("rst_rsp_flags", {bif.rsp_zero, bif.rsp_sign}, 2'b00);
    chk("rst_alu_ins", bif.alu_ins, 7'd0);
    chk("rst_alu_srca", bif.alu_srca, 32'd0);
    chk("rst_alu_srcb", bif.alu_srcb, 32'd0);
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Single ops from the table, checking latency edge by edge.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].id, vecs[i].ins, vecs[i].a, vecs[i].b,
            '{vecs[i].id, vecs[i].res, vecs[i].z, vecs[i].s});
      #1;
      chk("vec_ready", vecs[i].id ? bif.req1_ready : bif.req0_ready, 1'b1);
      chk("vec_other_ready", vecs[i].id ? bif.req0_ready : bif.req1_ready, 1'b0);
      tick();
      clear(vecs[i].id);
      chk("vec_lat1", bif.rsp_valid, 1'b0);
      tick();
      chk("vec_lat2", bif.rsp_valid, 1'b1);
      tick();
      chk("vec_done", bif.rsp_valid, 1'b0);
    end

    // Contention: both held valid for four cycles, grants alternate from req0.
    drive(1'b0, 7'b0000000, 32'd1, 32'd1, '{1'b0, 32'd2, 1'b0, 1'b0});
    drive(1'b1, 7'b0011010, 32'd12, 32'd3, '{1'b1, 32'd15, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req0_ready", bif.req0_ready, (i % 2) == 0);
      chk("rr_req1_ready", bif.req1_ready, (i % 2) == 1);
      chk("rr_rsp_valid", bif.rsp_valid, i >= 2);
      tick();
    end
    clear(1'b0);
    clear(1'b1);
    #1;
    chk("rr_stream3", bif.rsp_valid, 1'b1);
    tick();
    chk("rr_stream4", bif.rsp_valid, 1'b1);
    tick();
    chk("rr_end", bif.rsp_valid, 1'b0);

    // Backpressure: two ops fill s1+s2, third is refused until rsp_ready.
    bif.rsp_ready = 1'b0;
    drive(1'b0, 7'b0000000, 32'd10, 32'd20, '{1'b0, 32'd30, 1'b0, 1'b0});
    #1;
    chk("bp_ready1", bif.req0_ready, 1'b1);
    tick();
    drive(1'b0, 7'b0000001, 32'd100, 32'd1, '{1'b0, 32'd99, 1'b0, 1'b0});
    #1;
    chk("bp_ready2", bif.req0_ready, 1'b1);
    tick();
    drive(1'b0, 7'b0011010, 32'hF0, 32'h0F, '{1'b0, 32'hFF, 1'b0, 1'b0});
    #1;
    chk("bp_ready3", bif.req0_ready, 1'b0);
    chk("bp_rsp_valid", bif.rsp_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ready", bif.req0_ready, 1'b0);
      chk("bp_held_result", bif.rsp_result, 32'd30);
    end
    bif.rsp_ready = 1'b1;
    #1;
    chk("bp_resume_ready", bif.req0_ready, 1'b1);
    tick();
    clear(1'b0);
    drain();

    // Reset one cycle after an accept: op dropped, round-robin state restored.
    drive(1'b0, 7'b0000000, 32'h1000, 32'h0234, '{1'b0, 32'h1234, 1'b0, 1'b0});
    #1;
    tick();
    clear(1'b0);
    reset = 1'b1;
    tick();
    chk("mr_rsp_valid", bif.rsp_valid, 1'b0);
    chk("mr_rsp_result", bif.rsp_result, 32'd0);
    chk("mr_alu_ins", bif.alu_ins, 7'd0);
    chk("mr_alu_srca", bif.alu_srca, 32'd0);
    chk("mr_alu_srcb", bif.alu_srcb, 32'd0);
    drive(1'b0, 7'b0000000, 32'd2, 32'd2, '{1'b0, 32'd4, 1'b0, 1'b0});
    drive(1'b1, 7'b0011010, 32'd1, 32'd2, '{1'b1, 32'd3, 1'b0, 1'b0});
    #1;
    chk("mr_ready_in_reset", {bif.req0_ready, bif.req1_ready}, 2'b00);
    tick();
    reset = 1'b0;
    #1;
    chk("mr_idle", bif.rsp_valid, 1'b0);
    chk("mr_first_grant0", bif.req0_ready, 1'b1);
    chk("mr_first_grant1", bif.req1_ready, 1'b0);
    tick();
    chk("mr_second_grant", bif.req1_ready, 1'b1);
    chk("mr_no_stale", bif.rsp_valid, 1'b0);
    tick();
    clear(1'b0);
    clear(1'b1);
    drain();

    // Random traffic with random backpressure; valid held until accepted.
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(r == 0 ? bif.req0_valid : bif.req1_valid) && $urandom_range(0, 2) != 0) begin
          ins = rops[$urandom_range(0, 7)];
          a   = $urandom();
          b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
          m   = alu_model(ins, a, b);
          drive(r[0], ins, a, b, '{r[0], m[31:0], m[33], m[32]});
        end
      end
      bif.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc0 = bif.req0_valid & bif.req0_ready;
      acc1 = bif.req1_valid & bif.req1_ready;
      tick();
      if (acc0) clear(1'b0);
      if (acc1) clear(1'b1);
    end
    // Let any still-pending request finish its handshake before draining.
    bif.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!bif.req0_valid && !bif.req1_valid) break;
      @(negedge clk);
      acc0 = bif.req0_valid & bif.req0_ready;
      acc1 = bif.req1_valid & bif.req1_ready;
      tick();
      if (acc0) clear(1'b0);
      if (acc1) clear(1'b1);
    end
    chk("rand_req_flushed", {bif.req0_valid, bif.req1_valid}, 2'b00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
